apb_sum_multi: RTL
==================

# apb_sum_multi

Parametrised multi-channel APB accumulator slave, the successor of the single-channel sum peripheral. It sits behind the APB master and provides NUM_CH independent accumulators of DATA_W bits. Each accumulator supports add, subtract, clear and load operations, with optional saturation, sticky overflow and zero flags, and PSLVERR on bad addresses. Operation writes insert one wait state; all other transfers complete with zero wait states.

## Interface
Parameters:
- DATA_W, 32: accumulator and operand width, 8..32. PWDATA/PRDATA are always 32 bits; reads zero-extend, writes use the low DATA_W bits.
- NUM_CH, 4: number of channels, 1..16.
- SAT_EN, 0: 1 = saturate on overflow/underflow; 0 = wrap modulo 2^DATA_W.

Ports (one clock; reset is asynchronous and active-low):
- PCLK  in  1  clock, rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data, valid while PREADY=1 on a read.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response, valid while PREADY=1.

## Operation
- Channel c base address = 16*c. Register offsets within a channel:
  - +0 ADDV (RW): operand.
  - +4 CTRL: write bit0 = start, bits[2:1] = op (00 add, 01 sub, 10 clear, 11 load ADDV). Reads return the last op in bits[2:1]; bit0 reads 0.
  - +8 RES (RO): accumulator.
  - +12 STAT: bit0 = ovf, sticky; bit1 = zero (RES==0), live. Writing 1 to bit0 clears ovf.
- Any of the following gives PSLVERR=1 with no state change and PRDATA=0:
  - PADDR[1:0] ≠ 0.
  - PADDR ≥ 16*NUM_CH.
  - A write to RES.
- Add: computed on DATA_W+1 bits. Carry out sets ovf. Result is RES_max (all ones) if SAT_EN, else the wrapped value.
- Sub: computed as RES − ADDV. Borrow sets ovf. Result is 0 if SAT_EN, else the wrapped value.
- Clear and load never set ovf.
- A CTRL write with start=0 updates the stored op only.
- Channels are fully independent; an operation touches only its own channel's RES and ovf.
- FSM states:
  - IDLE: PREADY=0. On PSEL & !PENABLE, latch and decode the address. Go to EXEC if this is a valid CTRL write with PWDATA[0]=1; otherwise go to RESP.
  - EXEC: PREADY=0. Compute and register the new RES and ovf. Go to RESP.
  - RESP: PREADY=1. Drive PRDATA for reads; drive PSLVERR if the address was bad. Plain writes commit on this edge, when PSEL & PENABLE. Go to IDLE.
  - In EXEC or RESP, if PSEL falls (protocol violation), return to IDLE. No plain-write commit occurs; an EXEC result already registered stays.

## Timing
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, every ADDV/RES/op/ovf=0, FSM=IDLE.
- Assertion of PRESETn-low mid-transfer clears everything immediately, without waiting for a clock.
- Plain read or write: setup cycle, then the first access cycle has PREADY=1. Zero wait states; 2 cycles total.
- Start write: setup cycle, one access cycle with PREADY=0 (EXEC), then PREADY=1. One wait state; 3 cycles total.
- RES is updated at the end of EXEC. A RES read issued right after the start write returns the new value.
- PRDATA and PSLVERR are 0 whenever PREADY=0.
- Back-to-back transfers without an idle cycle are supported: RESP returns to IDLE, and the next setup is sampled there.

## Test plan
- Channel 0: ADDV=3, start add; ADDV=4, start add; ADDV=9, start add -> RES reads 16 after the three operations respectively: 3, 7, 16. STAT reads 0. Each start transfer shows exactly one PREADY=0 cycle.
- Channel 1, SAT_EN=0: ADDV=5 load, then ADDV=7 sub -> RES=0xFFFFFFFE, STAT.ovf=1. Write STAT=1 -> ovf=0. Same sequence with SAT_EN=1 -> RES=0, ovf=1.
- Add 1 to RES=0xFFFFFFFF with SAT_EN=0 -> RES=0, STAT=0x3 (ovf and zero both set).
- Channel independence: ops on channel 2 (ADDV=10, add) leave channel 3 RES=0; then a clear on channel 2 -> RES=0 and zero flag set.
- Error responses: read at 16*NUM_CH, read at 0x2, write to RES -> PREADY=1, PSLVERR=1, PRDATA=0, no register changes.
- Assert PRESETn low during the EXEC cycle -> PREADY=0 and RES=0 immediately. After release, a plain read completes with zero wait states.

Source files
------------

// File: rtl/apb_sum_multi.sv
// apb_sum_multi: APB slave with NUM_CH independent DATA_W-bit accumulators.
// Each channel occupies 16 bytes at base 16*c:
//   +0  ADDV  operand (RW)
//   +4  CTRL  bit0 start (write only), bits[2:1] op: 00 add, 01 sub, 10 clear, 11 load
//   +8  RES   accumulator (RO)
//   +12 STAT  bit0 sticky overflow (write 1 to clear), bit1 RES==0 (live)
// Start writes take one wait state; every other transfer has zero wait states.
// Ports:
//   PCLK, PRESETn                      clock, async active-low reset
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA  APB request
//   PRDATA, PREADY, PSLVERR            APB response (PRDATA/PSLVERR are 0 unless PREADY=1)
module apb_sum_multi #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int SAT_EN = 0
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_nxt;
    logic [CH_W-1:0]   lat_ch;
    logic [1:0]        lat_reg;
    logic [1:0]        lat_op;
    logic              lat_wr;
    logic              lat_err;

    logic [DATA_W-1:0] addv [NUM_CH];
    logic [DATA_W-1:0] res  [NUM_CH];
    logic [1:0]        op   [NUM_CH];
    logic [NUM_CH-1:0] ovf;

    logic              setup;
    logic              dec_bad;
    logic              dec_start;
    logic              commit;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] exec_res;
    logic              exec_ovf;
    logic [31:0]       rdata;

    // Address decode happens in the setup phase; the result is latched so the
    // access phase only looks at registered decode.
    always_comb begin
        setup     = (state == IDLE) && PSEL && !PENABLE;
        dec_bad   = (PADDR[1:0] != 2'b00) || (PADDR >= 32'(16 * NUM_CH)) ||
                    (PWRITE && (PADDR[3:2] == 2'd2));
        dec_start = !dec_bad && PWRITE && (PADDR[3:2] == 2'd1) && PWDATA[0];
        commit    = (state == RESP) && PSEL && PENABLE && lat_wr && !lat_err;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (setup) state_nxt = dec_start ? EXEC : RESP;
            EXEC: state_nxt = PSEL ? RESP : IDLE;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            lat_ch  <= '0;
            lat_reg <= '0;
            lat_op  <= '0;
            lat_wr  <= 1'b0;
            lat_err <= 1'b0;
        end else if (setup) begin
            lat_ch  <= PADDR[4 +: CH_W];
            lat_reg <= PADDR[3:2];
            lat_op  <= PWDATA[2:1];
            lat_wr  <= PWRITE;
            lat_err <= dec_bad;
        end
    end

    // Add/sub are done one bit wider so the top bit is the carry/borrow.
    always_comb begin
        sum      = {1'b0, res[lat_ch]} + {1'b0, addv[lat_ch]};
        diff     = {1'b0, res[lat_ch]} - {1'b0, addv[lat_ch]};
        exec_res = '0;
        exec_ovf = 1'b0;
        case (lat_op)
            2'b00: begin
                exec_ovf = sum[DATA_W];
                exec_res = (exec_ovf && (SAT_EN != 0)) ? '1 : sum[DATA_W-1:0];
            end
            2'b01: begin
                exec_ovf = diff[DATA_W];
                exec_res = (exec_ovf && (SAT_EN != 0)) ? '0 : diff[DATA_W-1:0];
            end
            2'b10: exec_res = '0;
            default: exec_res = addv[lat_ch];
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                addv[i] <= '0;
                res[i]  <= '0;
                op[i]   <= '0;
            end
            ovf <= '0;
        end else begin
            if (state == EXEC) begin
                res[lat_ch] <= exec_res;
                op[lat_ch]  <= lat_op;
                if (exec_ovf) ovf[lat_ch] <= 1'b1;
            end
            if (commit) begin
                case (lat_reg)
                    2'd0: addv[lat_ch] <= PWDATA[DATA_W-1:0];
                    2'd1: op[lat_ch]   <= PWDATA[2:1];
                    2'd3: if (PWDATA[0]) ovf[lat_ch] <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (lat_reg)
            2'd0: rdata[DATA_W-1:0] = addv[lat_ch];
            2'd1: rdata[2:1]        = op[lat_ch];
            2'd2: rdata[DATA_W-1:0] = res[lat_ch];
            default: begin
                rdata[0] = ovf[lat_ch];
                rdata[1] = (res[lat_ch] == '0);
            end
        endcase
    end

    always_comb begin
        PREADY  = (state == RESP);
        PSLVERR = (state == RESP) && lat_err;
        PRDATA  = ((state == RESP) && !lat_wr && !lat_err) ? rdata : 32'd0;
    end

endmodule
